// File: rtl/uioreg_evfifo.sv
// Register-mapped event mailbox: host writes stream to the core through a TX FIFO,
// core events queue in an RX FIFO drained by host reads, with level/overflow interrupt.
module uioreg_evfifo_fifo #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] head,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty,
   output logic          ovf
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] ONE = (AW+1)'(1);

   logic [DW-1:0] mem [0:DEPTH-1];
   logic [AW:0]   wp, rp;
   logic          do_push, do_pop;

   assign level   = wp - rp;
   assign full    = (level == DEPTH[AW:0]);
   assign empty   = (wp == rp);
   // a pop frees the slot on the same edge, so push-when-full with a pop still lands
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;
   assign ovf     = push & full & ~do_pop & ~flush;
   assign head    = mem[rp[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp <= '0;
         rp <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + ONE;
         if (do_pop)  rp <= rp + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= wdata;
   end
endmodule

module uioreg_evfifo #(
   parameter int ADDRESS_WIDTH = 14,
   parameter int DATA_WIDTH    = 32,
   parameter int TX_DEPTH_LOG2 = 4,
   parameter int RX_DEPTH_LOG2 = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [ADDRESS_WIDTH-1:0] con_adrout,
   input  logic [DATA_WIDTH-1:0]    con_dataout,
   input  logic                     con_write_out,
   input  logic                     con_read_out,
   input  logic                     con_chip_sel,
   output logic [DATA_WIDTH-1:0]    con_datain,
   output logic                     con_int_in_n,
   output logic [DATA_WIDTH-1:0]    tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   input  logic [DATA_WIDTH-1:0]    rx_data,
   input  logic                     rx_push
);
   logic [2:0]             wr_addr;
   logic                   rx_irq_en, ovf_irq_en, rx_ovf, tx_ovf;
   logic [7:0]             rx_thresh, thr_eff;
   logic                   wr_tx, wr_ctrl, wr_flags, rx_pop, tx_flush, rx_flush;
   logic                   tx_full, tx_empty, tx_ovf_evt, rx_full, rx_empty, rx_ovf_evt;
   logic [TX_DEPTH_LOG2:0] tx_level;
   logic [RX_DEPTH_LOG2:0] rx_level;
   logic [DATA_WIDTH-1:0]  rx_head;
   logic [7:0]             tx_lvl8, rx_lvl8;
   logic                   irq_cond;
   logic                   unused_adr;

   assign unused_adr = ^con_adrout[ADDRESS_WIDTH-1:3];

   // the bridge drops the address before the write strobe, so writes decode the latched one
   assign wr_tx    = con_write_out & (wr_addr == 3'd0);
   assign wr_ctrl  = con_write_out & (wr_addr == 3'd3);
   assign wr_flags = con_write_out & (wr_addr == 3'd4);
   assign tx_flush = wr_ctrl & con_dataout[30];
   assign rx_flush = wr_ctrl & con_dataout[31];
   assign rx_pop   = con_chip_sel & con_read_out & (con_adrout[2:0] == 3'd1);

   uioreg_evfifo_fifo #(.DW(DATA_WIDTH), .AW(TX_DEPTH_LOG2)) u_tx (
      .clk(clk), .reset_n(reset_n), .push(wr_tx), .pop(tx_ready), .flush(tx_flush),
      .wdata(con_dataout), .head(tx_data), .level(tx_level), .full(tx_full),
      .empty(tx_empty), .ovf(tx_ovf_evt));

   uioreg_evfifo_fifo #(.DW(DATA_WIDTH), .AW(RX_DEPTH_LOG2)) u_rx (
      .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
      .wdata(rx_data), .head(rx_head), .level(rx_level), .full(rx_full),
      .empty(rx_empty), .ovf(rx_ovf_evt));

   assign tx_valid = ~tx_empty;
   assign tx_lvl8  = 8'(tx_level);
   assign rx_lvl8  = 8'(rx_level);
   assign thr_eff  = (rx_thresh == 8'd0) ? 8'd1 : rx_thresh;
   assign irq_cond = (rx_irq_en & (rx_lvl8 >= thr_eff)) | (ovf_irq_en & (rx_ovf | tx_ovf));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_addr      <= '0;
         rx_irq_en    <= 1'b0;
         ovf_irq_en   <= 1'b0;
         rx_thresh    <= '0;
         rx_ovf       <= 1'b0;
         tx_ovf       <= 1'b0;
         con_int_in_n <= 1'b1;
      end else begin
         if (con_chip_sel && !con_read_out) wr_addr <= con_adrout[2:0];
         if (wr_ctrl) begin
            rx_irq_en  <= con_dataout[0];
            ovf_irq_en <= con_dataout[1];
            rx_thresh  <= con_dataout[15:8];
         end
         // a new overflow beats a same-cycle clear
         rx_ovf       <= rx_ovf_evt | (rx_ovf & ~(wr_flags & con_dataout[0]));
         tx_ovf       <= tx_ovf_evt | (tx_ovf & ~(wr_flags & con_dataout[1]));
         con_int_in_n <= ~irq_cond;
      end
   end

   always_comb begin
      con_datain = '0;
      case (con_adrout[2:0])
         3'd1: con_datain = rx_empty ? '0 : rx_head;
         3'd2: con_datain = DATA_WIDTH'({10'b0, tx_ovf, rx_ovf, rx_empty, rx_full,
                                         tx_empty, tx_full, rx_lvl8, tx_lvl8});
         3'd3: con_datain = DATA_WIDTH'({16'b0, rx_thresh, 6'b0, ovf_irq_en, rx_irq_en});
         3'd4: con_datain = DATA_WIDTH'({tx_ovf, rx_ovf});
         default: con_datain = '0;
      endcase
   end
endmodule

// File: tb/tb_uioreg_evfifo.sv
// Directed bench for uioreg_evfifo: bridge-style register accesses plus core-side streams.
module tb_uioreg_evfifo;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [13:0] con_adrout = '0;
   logic [31:0] con_dataout = '0;
   logic        con_write_out = 1'b0, con_read_out = 1'b0, con_chip_sel = 1'b0;
   logic [31:0] con_datain;
   logic        con_int_in_n;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] rx_data = '0;
   logic        rx_push = 1'b0;

   int checks = 0;
   int failures = 0;
   logic [31:0] rd;

   uioreg_evfifo dut (
      .clk(clk), .reset_n(reset_n), .con_adrout(con_adrout), .con_dataout(con_dataout),
      .con_write_out(con_write_out), .con_read_out(con_read_out), .con_chip_sel(con_chip_sel),
      .con_datain(con_datain), .con_int_in_n(con_int_in_n), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_push(rx_push));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // address cycle, then strobe cycle with the address moved elsewhere
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic push_rx);
      @(negedge clk);
      con_adrout = 14'(a); con_chip_sel = 1'b1; con_read_out = 1'b0;
      @(negedge clk);
      con_adrout = 14'h3ffe; con_chip_sel = 1'b0;
      con_write_out = 1'b1; con_dataout = d;
      if (push_rx) begin rx_push = 1'b1; rx_data = 32'hdead_0000; end
      @(negedge clk);
      con_write_out = 1'b0; rx_push = 1'b0; con_dataout = '0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      con_adrout = 14'(a); con_chip_sel = 1'b1; con_read_out = 1'b1;
      #1 d = con_datain;
      @(negedge clk);
      con_chip_sel = 1'b0; con_read_out = 1'b0;
   endtask

   task automatic core_push(input logic [31:0] d);
      @(negedge clk);
      rx_push = 1'b1; rx_data = d;
      @(negedge clk);
      rx_push = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      bus_read(3'd2, rd); check("reset_status", rd, 32'h000A0000);
      bus_read(3'd3, rd); check("reset_ctrl", rd, 32'h0);
      bus_read(3'd4, rd); check("reset_flags", rd, 32'h0);
      check("reset_int_n", 32'(con_int_in_n), 32'h1);
      check("reset_tx_valid", 32'(tx_valid), 32'h0);

      // TX ordering
      bus_write(3'd0, 32'h11, 1'b0);
      bus_write(3'd0, 32'h22, 1'b0);
      bus_write(3'd0, 32'h33, 1'b0);
      bus_read(3'd2, rd); check("tx_level3", rd & 32'hFF, 32'h3);
      @(negedge clk); tx_ready = 1'b1;
      #1 check("tx_head0", tx_data, 32'h11);
      @(negedge clk); #1 check("tx_head1", tx_data, 32'h22);
      @(negedge clk); #1 check("tx_head2", tx_data, 32'h33);
      @(negedge clk); #1 check("tx_drained", 32'(tx_valid), 32'h0);
      tx_ready = 1'b0;

      // TX overflow, W1C, flush
      for (int i = 0; i < 17; i++) bus_write(3'd0, 32'h100 + 32'(i), 1'b0);
      bus_read(3'd2, rd); check("tx_ovf_status", rd, 32'h00290010);
      bus_write(3'd4, 32'h2, 1'b0);
      bus_read(3'd2, rd); check("tx_ovf_clear", rd, 32'h00090010);
      check("tx_head_first", tx_data, 32'h100);
      bus_write(3'd3, 32'h40000000, 1'b0);
      bus_read(3'd2, rd); check("tx_flush", rd, 32'h000A0000);

      // RX threshold interrupt
      bus_write(3'd3, 32'h00000301, 1'b0);
      bus_read(3'd3, rd); check("ctrl_rb", rd, 32'h00000301);
      core_push(32'hA);
      core_push(32'hB);
      @(negedge clk); check("irq_below_thr", 32'(con_int_in_n), 32'h1);
      core_push(32'hC);
      check("irq_latency", 32'(con_int_in_n), 32'h1);
      @(negedge clk); check("irq_asserted", 32'(con_int_in_n), 32'h0);
      bus_read(3'd1, rd); check("rx_pop_a", rd, 32'hA);
      @(negedge clk); check("irq_released", 32'(con_int_in_n), 32'h1);
      bus_read(3'd1, rd); check("rx_pop_b", rd, 32'hB);
      bus_read(3'd1, rd); check("rx_pop_c", rd, 32'hC);
      bus_read(3'd1, rd); check("rx_empty_read", rd, 32'h0);
      bus_read(3'd2, rd); check("rx_empty_status", rd, 32'h000A0000);
      bus_write(3'd3, 32'h0, 1'b0);

      // RX full with simultaneous push and pop
      for (int i = 0; i < 16; i++) core_push(32'h200 + 32'(i));
      bus_read(3'd2, rd); check("rx_full_status", rd, 32'h00061000);
      @(negedge clk);
      con_adrout = 14'd1; con_chip_sel = 1'b1; con_read_out = 1'b1;
      rx_push = 1'b1; rx_data = 32'h2FF;
      #1 check("rx_full_pop", con_datain, 32'h200);
      @(negedge clk);
      con_chip_sel = 1'b0; con_read_out = 1'b0; rx_push = 1'b0;
      bus_read(3'd2, rd); check("rx_pushpop_full", rd, 32'h00061000);
      core_push(32'h3FF);
      bus_read(3'd2, rd); check("rx_ovf_set", rd, 32'h00161000);
      bus_write(3'd3, 32'h2, 1'b0);
      repeat (2) @(negedge clk);
      check("irq_ovf", 32'(con_int_in_n), 32'h0);
      bus_write(3'd4, 32'h1, 1'b0);
      bus_read(3'd4, rd); check("rx_ovf_clear", rd, 32'h0);
      bus_read(3'd1, rd); check("rx_order_after_full", rd, 32'h201);

      // RX flush with a concurrent core push
      bus_write(3'd3, 32'h80000000, 1'b0);
      for (int i = 0; i < 5; i++) core_push(32'h300 + 32'(i));
      bus_read(3'd2, rd); check("rx_level5", rd, 32'h00020500);
      bus_write(3'd3, 32'h80000000, 1'b1);
      bus_read(3'd2, rd); check("rx_flush", rd, 32'h000A0000);
      bus_read(3'd3, rd); check("ctrl_after_flush", rd, 32'h0);

      // asynchronous reset mid-burst with irq active
      bus_write(3'd3, 32'h00000101, 1'b0);
      core_push(32'h55);
      for (int i = 0; i < 3; i++) bus_write(3'd0, 32'h400 + 32'(i), 1'b0);
      @(negedge clk); check("pre_reset_irq", 32'(con_int_in_n), 32'h0);
      con_adrout = 14'd2;
      #3 reset_n = 1'b0;
      #1;
      check("async_tx_valid", 32'(tx_valid), 32'h0);
      check("async_int_n", 32'(con_int_in_n), 32'h1);
      check("async_status", con_datain, 32'h000A0000);
      @(negedge clk); reset_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout: got no finish expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
